// File: rtl/stage_controller.sv
// rtl/stage_controller.sv - fighter game stage sequencer with hit-point tracking
module stage_controller #(
  parameter int HP_W       = 4,
  parameter int P1_HP_INIT = 5,
  parameter int P2_HP_INIT = 5,
  parameter int END_FRAMES = 180
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            frame_clk,
  input  logic            start_key,
  input  logic            hit_p1,
  input  logic            hit_p2,
  output logic            start_l,
  output logic            battle_l,
  output logic            win_l,
  output logic            lose_l,
  output logic [HP_W-1:0] p1_hp,
  output logic [HP_W-1:0] p2_hp,
  output logic            game_rst
);

  localparam int CW = $clog2(END_FRAMES) + 1;
  localparam logic [CW-1:0]   LAST_FRAME = CW'(END_FRAMES - 1);
  localparam logic [HP_W-1:0] P1_INIT    = HP_W'(P1_HP_INIT);
  localparam logic [HP_W-1:0] P2_INIT    = HP_W'(P2_HP_INIT);

  typedef enum logic [1:0] {S_START, S_BATTLE, S_WIN, S_LOSE} state_t;

  state_t          state;
  logic [CW-1:0]   frame_cnt;
  logic            frame_s1, frame_s2, frame_h;
  logic            key_s1, key_s2, key_h;
  logic            tick, press;
  logic [HP_W-1:0] p1_nxt, p2_nxt;

  assign tick  = frame_s2 & ~frame_h;
  assign press = key_s2 & ~key_h;

  // Saturating decrement; both hits of one cycle land together.
  always_comb begin
    p1_nxt = p1_hp;
    p2_nxt = p2_hp;
    if (hit_p1 && p1_hp != '0) p1_nxt = p1_hp - 1'b1;
    if (hit_p2 && p2_hp != '0) p2_nxt = p2_hp - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_START;
      start_l   <= 1'b1;
      battle_l  <= 1'b0;
      win_l     <= 1'b0;
      lose_l    <= 1'b0;
      game_rst  <= 1'b0;
      p1_hp     <= P1_INIT;
      p2_hp     <= P2_INIT;
      frame_cnt <= '0;
      frame_s1  <= 1'b0;
      frame_s2  <= 1'b0;
      frame_h   <= 1'b0;
      key_s1    <= 1'b0;
      key_s2    <= 1'b0;
      key_h     <= 1'b0;
    end else begin
      frame_s1 <= frame_clk;
      frame_s2 <= frame_s1;
      frame_h  <= frame_s2;
      key_s1   <= start_key;
      key_s2   <= key_s1;
      key_h    <= key_s2;
      game_rst <= 1'b0;
      case (state)
        S_START: begin
          frame_cnt <= '0;
          if (press) begin
            state    <= S_BATTLE;
            start_l  <= 1'b0;
            battle_l <= 1'b1;
            game_rst <= 1'b1;
            p1_hp    <= P1_INIT;
            p2_hp    <= P2_INIT;
          end
        end
        S_BATTLE: begin
          frame_cnt <= '0;
          p1_hp     <= p1_nxt;
          p2_hp     <= p2_nxt;
          // Player 1 dying wins over player 2 dying, so a double kill is a loss.
          if (p1_nxt == '0) begin
            state    <= S_LOSE;
            battle_l <= 1'b0;
            lose_l   <= 1'b1;
          end else if (p2_nxt == '0) begin
            state    <= S_WIN;
            battle_l <= 1'b0;
            win_l    <= 1'b1;
          end
        end
        default: begin
          if (tick) begin
            if (frame_cnt == LAST_FRAME) begin
              state     <= S_START;
              frame_cnt <= '0;
              win_l     <= 1'b0;
              lose_l    <= 1'b0;
              start_l   <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_controller.sv
// tb/tb_stage_controller.sv - directed vector bench for stage_controller
module tb_stage_controller;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start_key = 1'b0;
  logic       hit_p1 = 1'b0;
  logic       hit_p2 = 1'b0;
  logic       start_l, battle_l, win_l, lose_l, game_rst;
  logic [3:0] p1_hp, p2_hp;

  stage_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start_key(start_key),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .start_l(start_l), .battle_l(battle_l),
    .win_l(win_l), .lose_l(lose_l), .p1_hp(p1_hp), .p2_hp(p2_hp), .game_rst(game_rst)
  );

  always #10 Clk = ~Clk;

  localparam logic [3:0] ST_START  = 4'b1000;
  localparam logic [3:0] ST_BATTLE = 4'b0100;
  localparam logic [3:0] ST_WIN    = 4'b0010;
  localparam logic [3:0] ST_LOSE   = 4'b0001;

  typedef struct {
    logic       key, h1, h2;
    logic [3:0] stage, p1, p2;
    logic       grst;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi;

  function automatic void add(logic key, logic h1, logic h2, logic [3:0] st,
                              logic [3:0] p1, logic [3:0] p2, logic grst);
    vec_t v;
    v.key = key; v.h1 = h1; v.h2 = h2; v.stage = st; v.p1 = p1; v.p2 = p2; v.grst = grst;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st, input logic [3:0] p1,
                         input logic [3:0] p2, input logic grst);
    chk({tag, " stage"}, {28'd0, start_l, battle_l, win_l, lose_l}, {28'd0, st});
    chk({tag, " hp"}, {24'd0, p1_hp, p2_hp}, {24'd0, p1, p2});
    chk({tag, " game_rst"}, {31'd0, game_rst}, {31'd0, grst});
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start_key = vecs[i].key;
      hit_p1    = vecs[i].h1;
      hit_p2    = vecs[i].h2;
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].stage, vecs[i].p1, vecs[i].p2, vecs[i].grst);
    end
    start_key = 1'b0;
    hit_p1    = 1'b0;
    hit_p2    = 1'b0;
  endtask

  initial begin
    // Segment A: start, battle, player 2 knocked out by five hits
    repeat (2) add(0, 0, 0, ST_START, 5, 5, 0);
    add(1, 0, 0, ST_START, 5, 5, 0);
    add(1, 0, 0, ST_START, 5, 5, 0);
    add(1, 0, 0, ST_BATTLE, 5, 5, 1);
    repeat (7) add(1, 0, 0, ST_BATTLE, 5, 5, 0);
    for (int j = 0; j < 5; j++) begin
      add(0, 0, 1, (j == 4) ? ST_WIN : ST_BATTLE, 5, 4'(4 - j), 0);
      if (j < 4) repeat (3) add(0, 0, 0, ST_BATTLE, 5, 4'(4 - j), 0);
    end
    add(0, 0, 0, ST_WIN, 5, 0, 0);
    a_hi = vecs.size() - 1;
    // Segment B: new round, simultaneous hits down to a double kill
    b_lo = vecs.size();
    add(1, 0, 0, ST_START, 5, 0, 0);
    add(1, 0, 0, ST_START, 5, 0, 0);
    add(1, 0, 0, ST_BATTLE, 5, 5, 1);
    add(0, 0, 0, ST_BATTLE, 5, 5, 0);
    for (int j = 4; j >= 1; j--) add(0, 1, 1, ST_BATTLE, 4'(j), 4'(j), 0);
    add(0, 0, 0, ST_BATTLE, 1, 1, 0);
    add(0, 1, 1, ST_LOSE, 0, 0, 0);
    add(0, 0, 0, ST_LOSE, 0, 0, 0);
    add(0, 1, 0, ST_LOSE, 0, 0, 0);
    b_hi = vecs.size() - 1;
    // Segment C: fresh round, player 1 down to 2
    c_lo = vecs.size();
    add(1, 0, 0, ST_START, 5, 5, 0);
    add(1, 0, 0, ST_START, 5, 5, 0);
    add(1, 0, 0, ST_BATTLE, 5, 5, 1);
    add(0, 0, 0, ST_BATTLE, 5, 5, 0);
    add(0, 1, 0, ST_BATTLE, 4, 5, 0);
    add(0, 1, 0, ST_BATTLE, 3, 5, 0);
    add(0, 1, 0, ST_BATTLE, 2, 5, 0);
    c_hi = vecs.size() - 1;
    // Segment D: hits in START are ignored
    d_lo = vecs.size();
    add(0, 1, 0, ST_START, 5, 5, 0);
    add(0, 0, 1, ST_START, 5, 5, 0);
    add(0, 1, 1, ST_START, 5, 5, 0);
    add(0, 0, 0, ST_START, 5, 5, 0);
    d_hi = vecs.size() - 1;

    // Reset state
    repeat (2) cyc();
    chk_out("in_reset", ST_START, 5, 5, 0);
    Reset_n = 1'b1;
    cyc();
    chk_out("post_reset", ST_START, 5, 5, 0);

    run_vecs(0, a_hi);

    // WIN hold: 179 frames with hits and a key press mixed in
    for (int f = 1; f < 180; f++) begin
      frame_clk = 1'b1;
      hit_p1    = (f == 10);
      hit_p2    = (f == 11);
      start_key = (f == 20);
      cyc();
      hit_p1 = 1'b0;
      hit_p2 = 1'b0;
      cyc();
      frame_clk = 1'b0;
      start_key = 1'b0;
      cyc();
      cyc();
      if (f == 10 || f == 20 || f == 179) chk_out($sformatf("win_f%0d", f), ST_WIN, 5, 0, 0);
    end
    frame_clk = 1'b1;
    cyc();
    cyc();
    chk_out("tick180_seen", ST_WIN, 5, 0, 0);
    cyc();
    chk_out("tick180_start", ST_START, 5, 0, 0);
    frame_clk = 1'b0;
    cyc();
    cyc();

    run_vecs(b_lo, b_hi);

    // Reset from LOSE restores title screen asynchronously
    Reset_n = 1'b0;
    #1 chk_out("rst_lose", ST_START, 5, 5, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc();

    run_vecs(c_lo, c_hi);

    // Mid-cycle reset during BATTLE
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 chk_out("rst_battle", ST_START, 5, 5, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc();

    run_vecs(d_lo, d_hi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
